// File: rtl/mod_n_pkg.sv
// rtl/mod_n_pkg.sv - shared types and wrap rule for the mod-N sequence blocks
package mod_n_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Successor in the mod-N sequence; callers widen their operands to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] mod_n_next(input logic [MAX_WIDTH-1:0] value,
                                                      input logic [MAX_WIDTH-1:0] n);
    return (value == n - 64'd1) ? '0 : value + 64'd1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mod_n_inc.sv
// rtl/mod_n_inc.sv - combinational mod-N successor, shared with the incrementer
module mod_n_inc
  import mod_n_pkg::*;
#(
  parameter longint unsigned N     = 256,
  parameter int              WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next
);

  assign next = WIDTH'(mod_n_next(MAX_WIDTH'(value), MAX_WIDTH'(N)));

endmodule

// File: rtl/mod_n_seq_checker.sv
// rtl/mod_n_seq_checker.sv - locks onto a mod-N sequence and counts breaks and wraps
module mod_n_seq_checker
  import mod_n_pkg::*;
#(
  parameter longint unsigned N         = 256,
  parameter int              WIDTH     = 32,
  parameter int              LOCK_CNT  = 4,
  parameter int              LOSS_CNT  = 4,
  parameter int              CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wrap_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int CW = $clog2(max_int(LOCK_CNT, LOSS_CNT) + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t          state;
  logic            seeded;
  logic [CW-1:0]   match_cnt;
  logic [CW-1:0]   miss_cnt;
  logic [WIDTH-1:0] next_val;
  logic            in_range;
  logic            hit;

  mod_n_inc #(.N(N), .WIDTH(WIDTH)) u_inc (
    .value(data_in),
    .next (next_val)
  );

  assign in_range = MAX_WIDTH'(data_in) < MAX_WIDTH'(N);
  assign hit      = in_range && (data_in == expected);
  assign locked   = (state == LOCKED);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      seeded     <= 1'b0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (!in_range) begin
              seeded    <= 1'b0;
              match_cnt <= '0;
            end else if (!seeded || !hit) begin
              // First sample or a break: restart the run from this value.
              seeded    <= 1'b1;
              expected  <= next_val;
              match_cnt <= '0;
            end else if (match_cnt == CW'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              expected  <= next_val;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              expected  <= next_val;
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= next_val;
              miss_cnt <= '0;
              if (data_in == '0 && wrap_count != CNT_MAX)
                wrap_count <= wrap_count + 1'b1;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != CNT_MAX)
                err_count <= err_count + 1'b1;
              // Garbage values carry no position information, so keep expecting the old one.
              if (in_range)
                expected <= next_val;
              if (miss_cnt == CW'(LOSS_CNT - 1)) begin
                state     <= SEARCH;
                seeded    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
        endcase
      end
      if (clear) begin
        err_count  <= '0;
        wrap_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// tb/tb_mod_n_seq_checker.sv - scoreboard bench for mod_n_seq_checker
module tb_mod_n_seq_checker;

  localparam longint N        = 256;
  localparam int     LOCK_CNT = 4;
  localparam int     LOSS_CNT = 4;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] wrap_count;
  logic [31:0] expected;

  mod_n_seq_checker #(
    .N(256), .WIDTH(32), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .expected(expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] err;
    logic [15:0] wrap;
    logic [31:0] exp;
  } resp_t;

  resp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: sequence rules in plain integer arithmetic.
  bit     m_locked, m_seeded, m_pulse;
  int     m_match, m_miss;
  longint m_err, m_wrap, m_exp;

  function automatic void model_reset();
    m_locked = 0; m_seeded = 0; m_pulse = 0;
    m_match = 0; m_miss = 0;
    m_err = 0; m_wrap = 0; m_exp = 0;
  endfunction

  function automatic void model_step(input bit v, input longint d, input bit clr);
    bit inr, hit;
    m_pulse = 0;
    if (v) begin
      inr = (d < N);
      hit = inr && (d == m_exp);
      if (!m_locked) begin
        if (!inr) begin
          m_seeded = 0; m_match = 0;
        end else if (!m_seeded) begin
          m_seeded = 1; m_exp = (d + 1) % N; m_match = 0;
        end else if (hit) begin
          m_match++; m_exp = (d + 1) % N;
          if (m_match == LOCK_CNT) begin
            m_locked = 1; m_match = 0; m_miss = 0;
          end
        end else begin
          m_exp = (d + 1) % N; m_match = 0;
        end
      end else begin
        if (hit) begin
          m_exp = (d + 1) % N; m_miss = 0;
          if (d == 0 && m_wrap < 65535) m_wrap++;
        end else begin
          m_pulse = 1;
          if (m_err < 65535) m_err++;
          m_miss++;
          if (inr) m_exp = (d + 1) % N;
          if (m_miss == LOSS_CNT) begin
            m_locked = 0; m_seeded = 0; m_match = 0; m_miss = 0;
          end
        end
      end
    end
    if (clr) begin
      m_err = 0; m_wrap = 0;
    end
  endfunction

  function automatic void push_model();
    resp_t r;
    r.locked = m_locked;
    r.pulse  = m_pulse;
    r.err    = m_err[15:0];
    r.wrap   = m_wrap[15:0];
    r.exp    = m_exp[31:0];
    q.push_back(r);
  endfunction

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endfunction

  task automatic apply(input bit v, input longint d, input bit clr);
    @(posedge clk);
    #1;
    in_valid = v;
    data_in  = d[31:0];
    clear    = clr;
    model_step(v, d, clr);
    push_model();
  endtask

  // Asserts reset between falling edges and checks the outputs clear without a clock edge.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    model_reset();
    #1;
    chk("rst_locked", 64'(locked), 64'(m_locked));
    chk("rst_pulse",  64'(err_pulse), 64'(m_pulse));
    chk("rst_err",    64'(err_count), 64'(m_err));
    chk("rst_wrap",   64'(wrap_count), 64'(m_wrap));
    chk("rst_exp",    64'(expected), 64'(m_exp));
    #1;
    rst = 1'b0;
    model_step(0, 0, 0);
    push_model();
  endtask

  task automatic feed_run(input longint start, input int len);
    for (int i = 0; i < len; i++) apply(1, (start + i) % N, 0);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked",     64'(locked),     64'(e.locked));
        chk("err_pulse",  64'(err_pulse),  64'(e.pulse));
        chk("err_count",  64'(err_count),  64'(e.err));
        chk("wrap_count", 64'(wrap_count), 64'(e.wrap));
        chk("expected",   64'(expected),   64'(e.exp));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    longint d;
    int     r;
    model_reset();
    #2;
    chk("init_locked", 64'(locked), 64'(0));
    chk("init_err",    64'(err_count), 64'(0));
    chk("init_exp",    64'(expected), 64'(0));
    #1;
    rst = 1'b0;

    feed_run(10, 5);
    pulse_reset();
    feed_run(249, 5);
    feed_run(254, 4);
    pulse_reset();
    feed_run(15, 5);
    apply(1, 50, 0);
    apply(1, 51, 0);
    apply(1, 52, 0);
    for (int i = 0; i < 4; i++) apply(1, 300, 0);
    feed_run(7, 5);
    pulse_reset();
    feed_run(5, 2);
    pulse_reset();
    feed_run(0, 5);
    apply(1, 99, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        pulse_reset();
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      d = m_exp;
        else if (r < 82) d = longint'($urandom_range(0, 255));
        else if (r < 92) d = 256 + longint'($urandom_range(0, 1000));
        else             d = {32'b0, $urandom()};
        apply($urandom_range(0, 99) < 88, d, $urandom_range(0, 99) < 3);
      end
    end

    apply(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_n_seq_checker.md
# mod_n_seq_checker

Receive-side checker for the mod-N sequence produced by the team's mod-N incrementer. It samples a stream of WIDTH-bit values and locks onto the sequence. Once locked, it flags every sample that is not the predecessor + 1 mod N, counts errors and wrap-arounds, and drops lock after repeated misses. It sits downstream of the incrementer in the negative-edge test designs as a self-check monitor.

## Interface
- N, 256, modulus; legal values 0..N-1; N ≥ 2, N ≤ 2^WIDTH
- WIDTH, 32, data width
- LOCK_CNT, 4, consecutive matches after the seed needed to lock; ≥ 1
- LOSS_CNT, 4, consecutive mismatches while locked that drop lock; ≥ 1
- CNT_WIDTH, 16, width of err_count / wrap_count
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  data_in is sampled on this falling edge
- data_in  in  WIDTH  sequence value under test
- clear  in  1  synchronous clear of err_count and wrap_count
- locked  out  1  high in LOCKED state
- err_pulse  out  1  one-cycle flag for a mismatch while LOCKED
- err_count  out  CNT_WIDTH  saturating mismatch count (LOCKED only)
- wrap_count  out  CNT_WIDTH  saturating count of verified N-1→0 transitions
- expected  out  WIDTH  value expected on the next valid sample

## Operation
- Define inc(x) = (x == N-1) ? 0 : x+1.
- A sample "matches" when data_in < N and data_in == expected.
- Out-of-range samples (≥ N) never match.
- SEARCH state:
  - First valid in-range sample with seeded=0 → seeded=1, expected=inc(data_in), match_cnt=0.
  - Match → match_cnt+1 and expected=inc(data_in). When match_cnt reaches LOCK_CNT → LOCKED, match_cnt=0, miss_cnt=0.
  - In-range mismatch → re-seed: expected=inc(data_in), match_cnt=0.
  - Out-of-range sample → seeded=0, match_cnt=0.
  - No err_pulse and no counting in SEARCH.
- LOCKED state:
  - Match → expected=inc(data_in) and miss_cnt=0. If data_in==0, wrap_count+1.
  - Mismatch → err_pulse=1, err_count+1, miss_cnt+1.
    - In-range: expected=inc(data_in) (resync).
    - Out-of-range: expected holds.
  - When miss_cnt reaches LOSS_CNT → SEARCH, seeded=0, match_cnt=0.
- Counters saturate at all-ones.
- clear zeroes err_count and wrap_count. Clear wins over a coincident increment; err_pulse still asserts.
- in_valid=0: no state, expected or counter change; err_pulse=0.

## Timing
- All outputs are registered and update on the falling clk edge that samples data_in; no combinational in-to-out path.
- err_pulse is high for exactly the cycle after the sampling edge, unless the next sample also mismatches.
- locked rises on the edge sampling the LOCK_CNT-th match, and falls on the edge sampling the LOSS_CNT-th consecutive miss.
- rst asserted: immediately, independent of clk:
  - state=SEARCH, seeded=0, match_cnt=0, miss_cnt=0
  - locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0
- Release of rst: first falling edge afterwards is a normal sampling edge.
- rst mid-stream discards lock; the sequence must re-seed.

## Structure
- Package mod_n_pkg:
  - state enum SEARCH=1'b0, LOCKED=1'b1
  - function for inc(), parameterised through module parameters passed as arguments
- Natural sub-module: mod_n_inc (combinational inc()). Shared with the incrementer so both ends agree on the wrap rule.
- Internal counters match_cnt and miss_cnt are sized $clog2(max(LOCK_CNT, LOSS_CNT)+1).

## Test plan
All scenarios use N=256, LOCK_CNT=4, LOSS_CNT=4.
- Reset, then 10,11,12,13,14 with in_valid=1 → locked=1 after the edge sampling 14; expected=15; err_count=0.
- Locked, feed 254,255,0,1 → wrap_count increments once (on the 0 sample); no err_pulse; expected=2.
- Locked at expected=20, feed 50 then 51 → err_pulse for one cycle, err_count=1, expected=51; then no error, still locked, expected=52.
- Locked, feed 300 four times → err_count+4, expected unchanged, locked=0 after the 4th; next 7,8,9,10,11 → relock.
- Locked, assert rst between falling edges → all outputs 0 before the next edge; after release, 5,6 gives locked=0.
- Locked, mismatch on the same edge as clear=1 → err_count=0, err_pulse=1; in_valid=0 for 3 edges → no output change.
